enemy_fire: RTL and testbench

Enemy-side projectile generator: the downward counterpart of the player's `shoot` path. It periodically fires a bullet from the enemy's current x position and advances the bullet toward the bottom of the screen. It detects hits against the player ship and tracks remaining lives. It sits beside the enemy movement logic and feeds bullet coordinates to the VGA draw path and hit/game-over status to the game controller.

---
 rtl/starflux_pkg.sv | 31 +++
 rtl/enemy_fire_if.sv | 31 +++
 rtl/rate_divider.sv | 32 +++
 rtl/enemy_fire.sv | 116 +++++++++++
 tb/tb_enemy_fire.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/starflux_pkg.sv
// Shared game-wide definitions: coordinate width, screen rows and the enemy-fire state encoding.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package starflux_pkg;

  localparam int COORD_W = 8;
  localparam int LIVES_W = 2;

  // Screen geometry in pixel rows (0 is the top row).
  localparam logic [COORD_W-1:0] SCREEN_BOTTOM = 8'd119;
  localparam logic [COORD_W-1:0] SHIP_Y        = 8'd110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_HIT  = 2'd2,
    ST_DEAD = 2'd3
  } fire_state_t;

  // Distance between two x coordinates. One extra bit keeps the subtraction
  // from wrapping; the larger operand is always the minuend.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    logic [COORD_W:0] wa;
    logic [COORD_W:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa > wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/enemy_fire_if.sv
// Bundle between enemy_fire and its neighbours: game enable, enemy/ship x in; bullet and status out.
// Latency: wires only.
// Backpressure: none; enable is the only stall control.
// Ports (master = enemy_fire side):
//   enable, x_val_enemy, x_val_ship            -> into enemy_fire
//   x_val_bullet, y_val_bullet, bullet_active,
//   player_hit, lives, game_over               <- out of enemy_fire
interface enemy_fire_if;
  import starflux_pkg::*;

  logic                 enable;
  logic [COORD_W-1:0]   x_val_enemy;
  logic [COORD_W-1:0]   x_val_ship;
  logic [COORD_W-1:0]   x_val_bullet;
  logic [COORD_W-1:0]   y_val_bullet;
  logic                 bullet_active;
  logic                 player_hit;
  logic [LIVES_W-1:0]   lives;
  logic                 game_over;

  modport master (
    input  enable, x_val_enemy, x_val_ship,
    output x_val_bullet, y_val_bullet, bullet_active, player_hit, lives, game_over
  );

  modport slave (
    output enable, x_val_enemy, x_val_ship,
    input  x_val_bullet, y_val_bullet, bullet_active, player_hit, lives, game_over
  );

endinterface

// File: rtl/rate_divider.sv
// Reloadable down-counter producing a one-clock tick every RELOAD+1 enabled clocks.
// Latency: tick is high during the clock in which the count is zero; reload happens on that edge.
// Backpressure: enable low freezes the count and suppresses tick.
// Ports: clock, reset (async, high), enable in; tick out (clock-enable, never a clock).
module rate_divider #(
  parameter int               WIDTH  = 28,
  parameter logic [WIDTH-1:0] RELOAD = '0
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= RELOAD;
    end else if (enable) begin
      if (count == '0) begin
        count <= RELOAD;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  // Gated by enable so a frozen divider parked at zero does not fire repeatedly.
  assign tick = enable && (count == '0);

endmodule

// File: rtl/enemy_fire.sv
// Enemy bullet generator: fires from the enemy x after a cooldown, moves down one row per tick, scores ship hits.
// Latency: all outputs registered; fire/step/hit take effect on the edge ending the tick clock, HIT->IDLE/DEAD one clock later.
// Backpressure: enable low holds divider, state and coordinates in IDLE/FLY; HIT completes regardless; DEAD is sticky until reset.
// Ports: clock, reset (async, high); bus (enemy_fire_if.master): enable, x_val_enemy, x_val_ship in;
//        x_val_bullet, y_val_bullet, bullet_active, player_hit, lives, game_over out.
module enemy_fire #(
  parameter logic [27:0] TICK_COUNT     = 28'd2499999,
  parameter logic [7:0]  COOLDOWN_TICKS = 8'd8,
  parameter logic [7:0]  SHIP_Y         = starflux_pkg::SHIP_Y,
  parameter logic [7:0]  SCREEN_BOTTOM  = starflux_pkg::SCREEN_BOTTOM,
  parameter logic [7:0]  HIT_HALF_WIDTH = 8'd4,
  parameter logic [1:0]  LIVES_INIT     = 2'd3
) (
  input  logic          clock,
  input  logic          reset,
  enemy_fire_if.master  bus
);

  localparam int CW = starflux_pkg::COORD_W;
  localparam int LW = starflux_pkg::LIVES_W;

  logic                      tick;
  starflux_pkg::fire_state_t state;
  logic [7:0]                cooldown;
  logic [CW-1:0]             x_bullet;
  logic [CW-1:0]             y_bullet;
  logic                      active_q;
  logic                      hit_q;
  logic [LW-1:0]             lives_q;
  logic                      over_q;
  logic                      x_aligned;
  logic [LW-1:0]             lives_dec;

  rate_divider #(
    .WIDTH  (28),
    .RELOAD (TICK_COUNT)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (bus.enable),
    .tick   (tick)
  );

  assign x_aligned = (starflux_pkg::abs_diff(x_bullet, bus.x_val_ship) <= {1'b0, HIT_HALF_WIDTH});
  assign lives_dec = (lives_q == '0) ? '0 : (lives_q - 1'b1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= starflux_pkg::ST_IDLE;
      cooldown <= COOLDOWN_TICKS;
      x_bullet <= '0;
      y_bullet <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      lives_q  <= LIVES_INIT;
      over_q   <= 1'b0;
    end else begin
      // player_hit is only ever raised on entry to HIT, which lasts one clock.
      hit_q <= 1'b0;
      case (state)
        starflux_pkg::ST_IDLE: begin
          if (tick) begin
            if (cooldown != 8'd0) begin
              cooldown <= cooldown - 8'd1;
            end else begin
              x_bullet <= bus.x_val_enemy;
              y_bullet <= '0;
              active_q <= 1'b1;
              state    <= starflux_pkg::ST_FLY;
            end
          end
        end
        starflux_pkg::ST_FLY: begin
          if (tick) begin
            if ((y_bullet == SHIP_Y) && x_aligned) begin
              active_q <= 1'b0;
              hit_q    <= 1'b1;
              lives_q  <= lives_dec;
              state    <= starflux_pkg::ST_HIT;
            end else if (y_bullet == SCREEN_BOTTOM) begin
              active_q <= 1'b0;
              cooldown <= COOLDOWN_TICKS;
              state    <= starflux_pkg::ST_IDLE;
            end else begin
              y_bullet <= y_bullet + 8'd1;
            end
          end
        end
        starflux_pkg::ST_HIT: begin
          // lives_q already holds the decremented count here.
          if (lives_q == '0) begin
            over_q <= 1'b1;
            state  <= starflux_pkg::ST_DEAD;
          end else begin
            cooldown <= COOLDOWN_TICKS;
            state    <= starflux_pkg::ST_IDLE;
          end
        end
        starflux_pkg::ST_DEAD: begin
          over_q <= 1'b1;
        end
        default: begin
          state <= starflux_pkg::ST_IDLE;
        end
      endcase
    end
  end

  assign bus.x_val_bullet  = x_bullet;
  assign bus.y_val_bullet  = y_bullet;
  assign bus.bullet_active = active_q;
  assign bus.player_hit    = hit_q;
  assign bus.lives         = lives_q;
  assign bus.game_over     = over_q;

endmodule

// File: tb/tb_enemy_fire.sv
// Scoreboard bench for enemy_fire: stimulus queues expected output snapshots tagged with the
// clock-edge count since reset release; a monitor compares every observed output change.
// Reset assertion is always checked one time unit after the asynchronous edge.
module tb_enemy_fire;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       act;
    logic       hit;
    logic [1:0] lives;
    logic       go;
  } snap_t;

  typedef struct packed {
    logic [31:0] e;
    snap_t       s;
  } exp_t;

  logic   clock;
  logic   reset;
  int     edge_cnt;
  int     n_checks;
  int     n_fail;
  exp_t   q[$];

  enemy_fire_if bus();

  enemy_fire #(
    .TICK_COUNT     (28'd3),
    .COOLDOWN_TICKS (8'd2),
    .SHIP_Y         (8'd5),
    .SCREEN_BOTTOM  (8'd7),
    .HIT_HALF_WIDTH (8'd1),
    .LIVES_INIT     (2'd3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Edges since reset release; the monitor reads it mid-cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic push(input int e, input int x, input int y, input bit act,
                      input bit hit, input int lives, input bit go);
    exp_t t;
    t.e       = e;
    t.s.x     = x[7:0];
    t.s.y     = y[7:0];
    t.s.act   = act;
    t.s.hit   = hit;
    t.s.lives = lives[1:0];
    t.s.go    = go;
    q.push_back(t);
  endtask

  // Bullet in flight: y = k appears k ticks (4 clocks each) after fire_e.
  task automatic push_fly(input int fire_e, input int k0, input int k1, input int x, input int lives);
    for (int k = k0; k <= k1; k++) push(fire_e + 4 * k, x, k, 1'b1, 1'b0, lives, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    push(0, 0, 0, 1'b0, 1'b0, 3, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic check(input snap_t cur, input int e);
    exp_t t;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event edge=%0d got x=%0d y=%0d act=%0b hit=%0b lives=%0d go=%0b",
               e, cur.x, cur.y, cur.act, cur.hit, cur.lives, cur.go);
    end else begin
      t = q.pop_front();
      if (t.e !== e || t.s !== cur) begin
        n_fail++;
        $display("FAIL event got edge=%0d x=%0d y=%0d act=%0b hit=%0b lives=%0d go=%0b required edge=%0d x=%0d y=%0d act=%0b hit=%0b lives=%0d go=%0b",
                 e, cur.x, cur.y, cur.act, cur.hit, cur.lives, cur.go,
                 t.e, t.s.x, t.s.y, t.s.act, t.s.hit, t.s.lives, t.s.go);
      end
    end
  endtask

  // Monitor: every change of the output bundle is one event.
  initial begin
    snap_t cur;
    snap_t prev;
    bit    in_reset;
    bit    started;
    in_reset = 1'b0;
    started  = 1'b0;
    prev     = '0;
    forever begin
      @(negedge clock or posedge reset);
      #1;
      cur.x     = bus.x_val_bullet;
      cur.y     = bus.y_val_bullet;
      cur.act   = bus.bullet_active;
      cur.hit   = bus.player_hit;
      cur.lives = bus.lives;
      cur.go    = bus.game_over;
      if (reset) begin
        if (!in_reset) begin
          in_reset = 1'b1;
          started  = 1'b1;
          check(cur, 0);
        end
        prev = cur;
      end else if (started) begin
        in_reset = 1'b0;
        if (cur !== prev) begin
          check(cur, edge_cnt);
          prev = cur;
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.enable      = 1'b1;
    bus.x_val_enemy = 8'd40;
    bus.x_val_ship  = 8'd60;

    // A: first fire on 3rd tick, full miss flight, retire, refire latches new enemy x.
    do_reset();
    push_fly(12, 0, 7, 40, 3);
    push(44, 40, 7, 1'b0, 1'b0, 3, 1'b0);
    push(56, 50, 0, 1'b1, 1'b0, 3, 1'b0);
    repeat (20) @(negedge clock);
    bus.x_val_enemy = 8'd50;
    repeat (38) @(negedge clock);

    // B: hit at ship x=41, hit at x=39, miss at x=42.
    bus.x_val_enemy = 8'd40;
    bus.x_val_ship  = 8'd41;
    do_reset();
    push_fly(12, 0, 5, 40, 3);
    push(36, 40, 5, 1'b0, 1'b1, 2, 1'b0);
    push(37, 40, 5, 1'b0, 1'b0, 2, 1'b0);
    push_fly(48, 0, 5, 40, 2);
    push(72, 40, 5, 1'b0, 1'b1, 1, 1'b0);
    push(73, 40, 5, 1'b0, 1'b0, 1, 1'b0);
    push_fly(84, 0, 7, 40, 1);
    push(116, 40, 7, 1'b0, 1'b0, 1, 1'b0);
    repeat (40) @(negedge clock);
    bus.x_val_ship = 8'd39;
    repeat (36) @(negedge clock);
    bus.x_val_ship = 8'd42;
    repeat (44) @(negedge clock);

    // C: three consecutive hits -> game over, then nothing with enable toggling.
    bus.x_val_ship = 8'd40;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      push_fly(12 + 36 * j, 0, 5, 40, 3 - j);
      push(36 + 36 * j, 40, 5, 1'b0, 1'b1, 2 - j, 1'b0);
      push(37 + 36 * j, 40, 5, 1'b0, 1'b0, 2 - j, (j == 2));
    end
    repeat (115) @(negedge clock);
    for (int i = 0; i < 90; i++) begin
      @(negedge clock);
      bus.enable = ((i % 3) != 0);
    end
    bus.enable = 1'b1;
    repeat (10) @(negedge clock);

    // D: enable low for 10 clocks mid-flight shifts motion by exactly 10 clocks.
    bus.x_val_ship = 8'd60;
    do_reset();
    push_fly(12, 0, 2, 40, 3);
    push_fly(22, 3, 7, 40, 3);
    push(54, 40, 7, 1'b0, 1'b0, 3, 1'b0);
    repeat (22) @(negedge clock);
    bus.enable = 1'b0;
    repeat (10) @(negedge clock);
    bus.enable = 1'b1;
    repeat (30) @(negedge clock);

    // E: two hits (lives=1), then async reset mid-flight at y=3; lives back to 3.
    bus.x_val_ship = 8'd40;
    do_reset();
    for (int j = 0; j < 2; j++) begin
      push_fly(12 + 36 * j, 0, 5, 40, 3 - j);
      push(36 + 36 * j, 40, 5, 1'b0, 1'b1, 2 - j, 1'b0);
      push(37 + 36 * j, 40, 5, 1'b0, 1'b0, 2 - j, 1'b0);
    end
    push_fly(84, 0, 3, 40, 1);
    repeat (76) @(negedge clock);
    bus.x_val_ship = 8'd60;
    repeat (21) @(negedge clock);
    do_reset();
    push(12, 40, 0, 1'b1, 1'b0, 3, 1'b0);
    repeat (14) @(negedge clock);

    repeat (2) @(negedge clock);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got %0d still queued required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
